// File: rtl/udma_jtag_fifo_dr_ctrl.sv
// JTAG USER data-register controller feeding the uDMA JTAG FIFO pair.
// A scan starts with a 4-bit header {size[1:0], opcode[1:0]} (LSB first),
// followed by a continuous stream of W-bit words until UPDATE-DR.
// RX handshake: data_rx_valid_o rises when a word completes and holds (data
// stable) until a TCK edge with data_rx_ready_i=1; a word completing while
// the held word is still pending is dropped and flagged in overflow_o.
// TX handshake: data_tx_ready_o is a combinational single-cycle pop, high
// only in a word-load cycle while data_tx_valid_i is high.
module udma_jtag_fifo_dr_ctrl #(
   parameter int  DATA_WIDTH = 32,
   localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  jtag_tck_i,
   input  logic                  jtag_trstn_i,
   input  logic                  jtag_tdi_i,
   output logic                  jtag_tdo_o,
   input  logic                  jtag_capture_dr_i,
   input  logic                  jtag_shift_dr_i,
   input  logic                  jtag_update_dr_i,
   output logic [DATA_WIDTH-1:0] data_rx_o,
   output logic [1:0]            data_rx_size_o,
   output logic                  data_rx_valid_o,
   input  logic                  data_rx_ready_i,
   input  logic [DATA_WIDTH-1:0] data_tx_i,
   input  logic                  data_tx_valid_i,
   output logic                  data_tx_ready_o,
   output logic                  overflow_o,
   output logic                  underflow_o,
   output logic [2:0]            dbg_state_o
);

   typedef enum logic [2:0] {
      ST_HDR = 3'd0,
      ST_RD  = 3'd1,
      ST_WR  = 3'd2,
      ST_RW  = 3'd3,
      ST_CLR = 3'd4
   } state_t;

   state_t                r_state,   w_state_nxt;
   logic [CNT_WIDTH-1:0]  r_cnt,     w_cnt_nxt;
   logic [3:0]            r_hdr,     w_hdr_nxt;
   logic [3:0]            r_status,  w_status_nxt;
   logic [1:0]            r_size,    w_size_nxt;
   logic [DATA_WIDTH-1:0] r_tx_sr,   w_tx_sr_nxt;
   logic [DATA_WIDTH-1:0] r_rx_sr,   w_rx_sr_nxt;
   logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data_nxt;
   logic [1:0]            r_rx_size, w_rx_size_nxt;
   logic                  r_rx_valid, w_rx_valid_nxt;
   logic                  r_ovf,     w_ovf_nxt;
   logic                  r_udf,     w_udf_nxt;

   logic [3:0]            w_hdr_word;
   logic [CNT_WIDTH-1:0]  w_wm1;
   logic [CNT_WIDTH-1:0]  w_wm1_hdr;
   logic [DATA_WIDTH-1:0] w_ld_mask;
   logic [DATA_WIDTH-1:0] w_rx_shr;
   logic [DATA_WIDTH-1:0] w_rx_next;
   logic                  w_is_shift;
   logic                  w_hdr_done;
   logic                  w_word_end;
   logic                  w_tx_state;
   logic                  w_rx_state;
   logic                  w_tx_load;

   // Index of the last bit of a word: W = 8<<size, clamped to DATA_WIDTH.
   function automatic logic [CNT_WIDTH-1:0] f_wm1(input logic [1:0] size);
      int w;
      w = 8 << size;
      if (w > DATA_WIDTH) w = DATA_WIDTH;
      return CNT_WIDTH'(w - 1);
   endfunction

   // Mask keeping bits [wm1:0] of a word.
   function automatic logic [DATA_WIDTH-1:0] f_mask(input logic [CNT_WIDTH-1:0] wm1);
      logic [DATA_WIDTH-1:0] m;
      for (int i = 0; i < DATA_WIDTH; i++) m[i] = (i <= int'(wm1));
      return m;
   endfunction

   assign w_is_shift = jtag_shift_dr_i & ~jtag_capture_dr_i & ~jtag_update_dr_i;
   assign w_hdr_word = {jtag_tdi_i, r_hdr[3:1]};
   assign w_hdr_done = (r_state == ST_HDR) && (r_cnt == CNT_WIDTH'(3));
   assign w_wm1      = f_wm1(r_size);
   assign w_wm1_hdr  = f_wm1(w_hdr_word[3:2]);
   assign w_word_end = (r_cnt == w_wm1);
   assign w_tx_state = (r_state == ST_RD) || (r_state == ST_RW);
   assign w_rx_state = (r_state == ST_WR) || (r_state == ST_RW);
   // RD (00) and RW (10) both have opcode bit0 clear and need a TX word at decode.
   assign w_tx_load  = w_is_shift &&
                       ((w_hdr_done && !w_hdr_word[0]) || (w_tx_state && w_word_end));
   assign w_ld_mask  = f_mask(w_hdr_done ? w_wm1_hdr : w_wm1);
   assign w_rx_shr   = r_rx_sr >> 1;

   assign data_tx_ready_o = w_tx_load & data_tx_valid_i;
   assign data_rx_o       = r_rx_data;
   assign data_rx_size_o  = r_rx_size;
   assign data_rx_valid_o = r_rx_valid;
   assign overflow_o      = r_ovf;
   assign underflow_o     = r_udf;
   assign dbg_state_o     = r_state;

   // RX shift: new bit enters at W-1, bits above W-1 stay zero (zero-extension).
   always_comb begin
      w_rx_next = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (i == int'(w_wm1))     w_rx_next[i] = jtag_tdi_i;
         else if (i < int'(w_wm1)) w_rx_next[i] = w_rx_shr[i];
      end
   end

   // TDO source: status during the header, TX word in read states, else 0.
   always_comb begin
      jtag_tdo_o = 1'b0;
      case (r_state)
         ST_HDR:       jtag_tdo_o = r_status[0];
         ST_RD, ST_RW: jtag_tdo_o = r_tx_sr[0];
         default:      jtag_tdo_o = 1'b0;
      endcase
   end

   // Next-state logic: capture > update > shift, RX handshake on every edge.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_hdr_nxt      = r_hdr;
      w_status_nxt   = r_status;
      w_size_nxt     = r_size;
      w_tx_sr_nxt    = r_tx_sr;
      w_rx_sr_nxt    = r_rx_sr;
      w_rx_data_nxt  = r_rx_data;
      w_rx_size_nxt  = r_rx_size;
      w_rx_valid_nxt = r_rx_valid;
      w_ovf_nxt      = r_ovf;
      w_udf_nxt      = r_udf;

      if (r_rx_valid && data_rx_ready_i) w_rx_valid_nxt = 1'b0;

      if (jtag_capture_dr_i) begin
         w_state_nxt  = ST_HDR;
         w_cnt_nxt    = '0;
         w_rx_sr_nxt  = '0;
         w_status_nxt = {r_udf, r_ovf, ~r_rx_valid, data_tx_valid_i};
      end else if (jtag_update_dr_i) begin
         w_state_nxt = ST_HDR;
         w_cnt_nxt   = '0;
         w_rx_sr_nxt = '0;
         if (r_state == ST_CLR) begin
            w_ovf_nxt = 1'b0;
            w_udf_nxt = 1'b0;
         end
      end else if (w_is_shift) begin
         if (r_state == ST_HDR) begin
            w_hdr_nxt    = w_hdr_word;
            w_status_nxt = r_status >> 1;
            if (w_hdr_done) begin
               w_cnt_nxt   = '0;
               w_size_nxt  = w_hdr_word[3:2];
               w_rx_sr_nxt = '0;
               case (w_hdr_word[1:0])
                  2'b00:   w_state_nxt = ST_RD;
                  2'b01:   w_state_nxt = ST_WR;
                  2'b10:   w_state_nxt = ST_RW;
                  default: w_state_nxt = ST_CLR;
               endcase
            end else begin
               w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
            end
         end else begin
            w_cnt_nxt = w_word_end ? '0 : r_cnt + CNT_WIDTH'(1);
         end

         if (w_tx_load) begin
            if (data_tx_valid_i) begin
               w_tx_sr_nxt = data_tx_i & w_ld_mask;
            end else begin
               w_tx_sr_nxt = '0;
               w_udf_nxt   = 1'b1;
            end
         end else if (w_tx_state) begin
            w_tx_sr_nxt = r_tx_sr >> 1;
         end

         if (w_rx_state) begin
            w_rx_sr_nxt = w_rx_next;
            if (w_word_end) begin
               if (!r_rx_valid || data_rx_ready_i) begin
                  w_rx_data_nxt  = w_rx_next;
                  w_rx_size_nxt  = r_size;
                  w_rx_valid_nxt = 1'b1;
               end else begin
                  w_ovf_nxt = 1'b1;
               end
            end
         end
      end
   end

   // State register, cleared asynchronously by TRST.
   always_ff @(posedge jtag_tck_i or negedge jtag_trstn_i) begin
      if (!jtag_trstn_i) begin
         r_state    <= ST_HDR;
         r_cnt      <= '0;
         r_hdr      <= '0;
         r_status   <= '0;
         r_size     <= '0;
         r_tx_sr    <= '0;
         r_rx_sr    <= '0;
         r_rx_data  <= '0;
         r_rx_size  <= '0;
         r_rx_valid <= 1'b0;
         r_ovf      <= 1'b0;
         r_udf      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_hdr      <= w_hdr_nxt;
         r_status   <= w_status_nxt;
         r_size     <= w_size_nxt;
         r_tx_sr    <= w_tx_sr_nxt;
         r_rx_sr    <= w_rx_sr_nxt;
         r_rx_data  <= w_rx_data_nxt;
         r_rx_size  <= w_rx_size_nxt;
         r_rx_valid <= w_rx_valid_nxt;
         r_ovf      <= w_ovf_nxt;
         r_udf      <= w_udf_nxt;
      end
   end

endmodule

// File: tb/tb_udma_jtag_fifo_dr_ctrl.sv
// Directed bench for udma_jtag_fifo_dr_ctrl: a 32-bit instance for the main
// scans and a 16-bit instance (same stimulus) for the size clamp and abort.
module tb_udma_jtag_fifo_dr_ctrl;

   localparam logic [2:0] S_HDR = 3'd0;
   localparam logic [2:0] S_RD  = 3'd1;
   localparam logic [2:0] S_WR  = 3'd2;
   localparam logic [2:0] S_RW  = 3'd3;
   localparam logic [2:0] S_CLR = 3'd4;

   logic        clk;
   logic        trstn;
   logic        tdi;
   logic        cap;
   logic        shift;
   logic        upd;
   logic        rx_ready;
   logic [31:0] tx_data;
   logic        tx_valid;

   logic        tdo32, rdy32, rxv32, ovf32, udf32;
   logic [31:0] rxd32;
   logic [1:0]  rxs32;
   logic [2:0]  st32;

   logic        tdo16, rdy16, rxv16, ovf16, udf16;
   logic [15:0] rxd16;
   logic [1:0]  rxs16;
   logic [2:0]  st16;

   logic [63:0] g_tdo;
   logic [63:0] g_rdy;
   logic [63:0] exp_q[$];
   int          n_cmp;
   int          n_err;

   udma_jtag_fifo_dr_ctrl #(.DATA_WIDTH(32)) u_dut32 (
      .jtag_tck_i        (clk),
      .jtag_trstn_i      (trstn),
      .jtag_tdi_i        (tdi),
      .jtag_tdo_o        (tdo32),
      .jtag_capture_dr_i (cap),
      .jtag_shift_dr_i   (shift),
      .jtag_update_dr_i  (upd),
      .data_rx_o         (rxd32),
      .data_rx_size_o    (rxs32),
      .data_rx_valid_o   (rxv32),
      .data_rx_ready_i   (rx_ready),
      .data_tx_i         (tx_data),
      .data_tx_valid_i   (tx_valid),
      .data_tx_ready_o   (rdy32),
      .overflow_o        (ovf32),
      .underflow_o       (udf32),
      .dbg_state_o       (st32)
   );

   udma_jtag_fifo_dr_ctrl #(.DATA_WIDTH(16)) u_dut16 (
      .jtag_tck_i        (clk),
      .jtag_trstn_i      (trstn),
      .jtag_tdi_i        (tdi),
      .jtag_tdo_o        (tdo16),
      .jtag_capture_dr_i (cap),
      .jtag_shift_dr_i   (shift),
      .jtag_update_dr_i  (upd),
      .data_rx_o         (rxd16),
      .data_rx_size_o    (rxs16),
      .data_rx_valid_o   (rxv16),
      .data_rx_ready_i   (rx_ready),
      .data_tx_i         (tx_data[15:0]),
      .data_tx_valid_i   (tx_valid),
      .data_tx_ready_o   (rdy16),
      .overflow_o        (ovf16),
      .underflow_o       (udf16),
      .dbg_state_o       (st16)
   );

   // Clock: 10 time-unit TCK period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_capture();
      @(negedge clk);
      cap = 1'b1; shift = 1'b0; upd = 1'b0;
      @(posedge clk); #1;
      cap = 1'b0;
   endtask

   task automatic do_update();
      @(negedge clk);
      upd = 1'b1; shift = 1'b0; cap = 1'b0;
      @(posedge clk); #1;
      upd = 1'b0;
   endtask

   task automatic do_idle();
      @(negedge clk);
      upd = 1'b0; shift = 1'b0; cap = 1'b0;
      @(posedge clk); #1;
   endtask

   // Shift n bits of v LSB first; record the 32-bit instance's TDO and pop per bit.
   task automatic shift_bits(input logic [63:0] v, input int n);
      g_tdo = '0;
      g_rdy = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         shift = 1'b1; tdi = v[i];
         #1;
         g_tdo[i] = tdo32;
         g_rdy[i] = rdy32;
         @(posedge clk); #1;
         shift = 1'b0;
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      trstn = 1'b0; tdi = 1'b0; cap = 1'b0; shift = 1'b0; upd = 1'b0;
      rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0;
      #2;
      chk("rst_tdo",   {63'd0, tdo32}, 64'd0);
      chk("rst_rxv",   {63'd0, rxv32}, 64'd0);
      chk("rst_rxd",   {32'd0, rxd32}, 64'd0);
      chk("rst_rxs",   {62'd0, rxs32}, 64'd0);
      chk("rst_rdy",   {63'd0, rdy32}, 64'd0);
      chk("rst_flags", {62'd0, ovf32, udf32}, 64'd0);
      chk("rst_state", {61'd0, st32}, {61'd0, S_HDR});
      @(negedge clk);
      trstn = 1'b1;

      // Status capture then WR 32-bit word 0xDEADBEEF.
      tx_valid = 1'b1; tx_data = 32'h0000_00A5; rx_ready = 1'b1;
      do_capture();
      shift_bits(64'h9, 4);
      chk("cap_status_tdo", {60'd0, g_tdo[3:0]}, 64'h3);
      chk("wr_hdr_nopop",   {60'd0, g_rdy[3:0]}, 64'h0);
      chk("wr_state",       {61'd0, st32}, {61'd0, S_WR});
      shift_bits(64'h5EADBEEF, 31);
      chk("wr_35_novalid",  {63'd0, rxv32}, 64'd0);
      chk("wr_nopop",       g_rdy, 64'd0);
      chk("wr_tdo_zero",    g_tdo, 64'd0);
      shift_bits(64'h1, 1);
      chk("wr_36_valid",    {63'd0, rxv32}, 64'd1);
      chk("wr_36_data",     {32'd0, rxd32}, 64'hDEADBEEF);
      chk("wr_36_size",     {62'd0, rxs32}, 64'd2);
      do_idle();
      chk("wr_valid_clear", {63'd0, rxv32}, 64'd0);
      do_update();
      chk("wr_upd_state",   {61'd0, st32}, {61'd0, S_HDR});

      // RD 8-bit: pops on shift edges 4 and 12, TDO 0xA5 then 0x3C.
      exp_q.push_back(64'hA5);
      exp_q.push_back(64'h3C);
      do_capture();
      shift_bits(64'h0, 4);
      chk("rd_hdr_pop",     {60'd0, g_rdy[3:0]}, 64'h8);
      chk("rd_state",       {61'd0, st32}, {61'd0, S_RD});
      tx_data = 32'h0000_003C;
      shift_bits(64'h0, 8);
      chk("rd_w0_tdo",      {56'd0, g_tdo[7:0]}, exp_q.pop_front());
      chk("rd_w0_pop",      {56'd0, g_rdy[7:0]}, 64'h80);
      tx_data = 32'h0000_0077;
      shift_bits(64'h0, 8);
      chk("rd_w1_tdo",      {56'd0, g_tdo[7:0]}, exp_q.pop_front());
      chk("rd_no_udf",      {63'd0, udf32}, 64'd0);
      do_update();

      // WR 8-bit with rx_ready low: second byte dropped.
      rx_ready = 1'b0;
      do_capture();
      shift_bits(64'h1, 4);
      shift_bits(64'h11, 8);
      chk("ovf_w0_valid",   {63'd0, rxv32}, 64'd1);
      chk("ovf_w0_data",    {32'd0, rxd32}, 64'h11);
      chk("ovf_w0_noflag",  {63'd0, ovf32}, 64'd0);
      shift_bits(64'h22, 8);
      chk("ovf_held_data",  {32'd0, rxd32}, 64'h11);
      chk("ovf_flag",       {63'd0, ovf32}, 64'd1);
      do_update();
      chk("ovf_sticky",     {63'd0, ovf32}, 64'd1);

      // CLR scan: status reflects overflow, flags clear on UPDATE.
      do_capture();
      shift_bits(64'h3, 4);
      chk("clr_status_tdo", {60'd0, g_tdo[3:0]}, 64'h5);
      shift_bits(64'h7, 3);
      chk("clr_state",      {61'd0, st32}, {61'd0, S_CLR});
      chk("clr_tdo_zero",   {61'd0, g_tdo[2:0]}, 64'd0);
      chk("clr_pre_upd",    {63'd0, ovf32}, 64'd1);
      do_update();
      chk("clr_ovf",        {63'd0, ovf32}, 64'd0);
      rx_ready = 1'b1;
      do_idle();
      chk("clr_rxv_drain",  {63'd0, rxv32}, 64'd0);

      // RW 16-bit with TX empty: zeros out, underflow, RX 0x1234.
      tx_valid = 1'b0;
      do_capture();
      shift_bits(64'h6, 4);
      chk("rw_state",       {61'd0, st32}, {61'd0, S_RW});
      chk("rw_udf_hdr",     {63'd0, udf32}, 64'd1);
      chk("rw_hdr_nopop",   {60'd0, g_rdy[3:0]}, 64'h0);
      shift_bits(64'h1234, 16);
      chk("rw_tdo_zero",    {48'd0, g_tdo[15:0]}, 64'd0);
      chk("rw_nopop",       g_rdy, 64'd0);
      chk("rw_rx_data",     {32'd0, rxd32}, 64'h1234);
      chk("rw_rx_size",     {62'd0, rxs32}, 64'd1);
      chk("rw_rx_valid",    {63'd0, rxv32}, 64'd1);
      do_update();
      chk("rw_udf_sticky",  {63'd0, udf32}, 64'd1);

      // Reset in the middle of a WR scan.
      tx_valid = 1'b1;
      do_capture();
      shift_bits(64'h9, 4);
      shift_bits(64'h5, 3);
      @(negedge clk);
      trstn = 1'b0;
      #1;
      chk("mid_rst_state",  {61'd0, st32}, {61'd0, S_HDR});
      chk("mid_rst_flags",  {62'd0, ovf32, udf32}, 64'd0);
      chk("mid_rst_rx",     {31'd0, rxv32, rxd32}, 64'd0);
      @(negedge clk);
      trstn = 1'b1;

      // 16-bit instance: size 3 clamps to 16 bits.
      rx_ready = 1'b1;
      do_capture();
      shift_bits(64'hD, 4);
      chk("c16_state",      {61'd0, st16}, {61'd0, S_WR});
      shift_bits(64'h3EEF, 15);
      chk("c16_15_novalid", {63'd0, rxv16}, 64'd0);
      shift_bits(64'h1, 1);
      chk("c16_valid",      {63'd0, rxv16}, 64'd1);
      chk("c16_data",       {48'd0, rxd16}, 64'hBEEF);
      chk("c16_size",       {62'd0, rxs16}, 64'd3);
      do_update();

      // Abort after 5 data bits: nothing delivered, back to header state.
      do_capture();
      shift_bits(64'hD, 4);
      shift_bits(64'h1F, 5);
      chk("abort_state_wr", {61'd0, st16}, {61'd0, S_WR});
      chk("abort_novalid",  {63'd0, rxv16}, 64'd0);
      do_update();
      chk("abort_state",    {61'd0, st16}, {61'd0, S_HDR});
      chk("abort_upd_nov",  {63'd0, rxv16}, 64'd0);
      do_capture();
      shift_bits(64'hD, 4);
      shift_bits(64'h0F0F, 16);
      chk("abort_next_data", {48'd0, rxd16}, 64'h0F0F);
      chk("abort_next_ovf",  {63'd0, ovf16}, 64'd0);
      do_update();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
